// File: rtl/ysyx_23060042_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060042_pkg
// Purpose  : Shared types and constants for the ysyx_23060042 fetch unit.
//            - ifu_state_e       : fetch FSM states
//            - RESET_PC_DEFAULT  : PC value loaded on reset
//            - INST_NOP          : instruction presented on a fetch fault
//            - PC_STEP           : sequential PC increment
//            - is_misaligned()   : instruction-address alignment test
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_23060042_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifu_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] PC_STEP          = 32'd4;

  // Instructions are word aligned; any set bit in [1:0] is a misaligned PC.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_23060042_ifu_pc.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060042_ifu_pc
// Purpose  : Program-counter register of the fetch unit with redirect /
//            sequential-advance selection. A redirect always wins over an
//            advance. The increment wraps modulo 2^32.
// Ports    : clk         in   1   core clock
//            rst_n       in   1   asynchronous active-low reset
//            redirect    in   1   load redirect_pc this cycle
//            advance     in   1   step PC by 4 this cycle
//            redirect_pc in  32   redirect target
//            pc          out 32   current program counter
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060042_ifu_pc
  import ysyx_23060042_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic        advance,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (advance) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule
`default_nettype wire

// File: rtl/ysyx_23060042_ifu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060042_ifu
// Purpose  : Instruction fetch unit. Owns the PC, issues one fetch at a time
//            to instruction memory (valid/ready request, valid-only
//            response), buffers the returned word and hands it to decode
//            through a valid/ready handshake. Execute-stage redirects replace
//            the PC and cancel any fetch whose response is still pending.
// Config   : IFU_MISALIGN_CHK_EN - when defined, a misaligned PC is not
//            fetched; a NOP is presented instead with out_fault=1.
// Ports    : clk             in   1   core clock
//            rst_n           in   1   asynchronous active-low reset
//            redirect_valid  in   1   PC change request from execute
//            redirect_pc     in  32   redirect target
//            imem_req_valid  out  1   fetch request valid
//            imem_req_ready  in   1   memory accepts request
//            imem_req_addr   out 32   fetch address (= current PC)
//            imem_rsp_valid  in   1   fetch response valid
//            imem_rsp_data   in  32   fetched instruction word
//            out_valid       out  1   instruction available to decode
//            out_ready       in   1   decode consumes instruction
//            out_inst        out 32   instruction word
//            out_pc          out 32   PC of out_inst
//            out_fault       out  1   instruction-address-misaligned flag
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_23060042_ifu
  import ysyx_23060042_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_fault
);

  ifu_state_e  state_q;
  logic        kill_q;      // the in-flight response belongs to a stale PC
  logic [31:0] inst_buf_q;
  logic        fault_q;     // HOLD is presenting a misaligned-PC fault

  logic [31:0] pc;
  logic        misalign;
  logic        pc_redirect;
  logic        pc_advance;

  // --------------------------------------------------------------------------
  // Misaligned-fetch detection (only meaningful while requesting)
  // --------------------------------------------------------------------------
`ifdef IFU_MISALIGN_CHK_EN
  assign misalign = (state_q == REQ) && is_misaligned(pc);
`else
  assign misalign = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // PC register. Redirects are ignored only in IDLE, which lasts exactly one
  // cycle after reset. Advance is only taken on a decode handshake; the
  // redirect priority inside the PC block suppresses it when both are high,
  // matching out_valid being forced low by a redirect.
  // --------------------------------------------------------------------------
  assign pc_redirect = redirect_valid && (state_q != IDLE);
  assign pc_advance  = (state_q == HOLD) && out_ready;

  ysyx_23060042_ifu_pc #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (pc_redirect),
    .advance     (pc_advance),
    .redirect_pc (redirect_pc),
    .pc          (pc)
  );

  // --------------------------------------------------------------------------
  // Outputs: decoded from registered state; out_valid is the one exception,
  // gated by a same-cycle redirect so a dying instruction is never consumed.
  // --------------------------------------------------------------------------
  assign imem_req_valid = (state_q == REQ) && !misalign;
  assign imem_req_addr  = pc;
  assign out_valid      = (state_q == HOLD) && !redirect_valid;
  assign out_inst       = inst_buf_q;
  assign out_pc         = pc;
  assign out_fault      = fault_q;

  // --------------------------------------------------------------------------
  // Fetch FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      kill_q     <= 1'b0;
      inst_buf_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= REQ;
        end

        REQ: begin
          if (misalign && !redirect_valid) begin
            // Misaligned PC: skip memory and present a faulting NOP.
            state_q    <= HOLD;
            inst_buf_q <= INST_NOP;
            fault_q    <= 1'b1;
          end else if (imem_req_valid && imem_req_ready) begin
            // The request went out with the old PC; if a redirect arrives
            // in the same cycle its response must be discarded.
            state_q <= WAIT;
            kill_q  <= redirect_valid;
          end
        end

        WAIT: begin
          if (redirect_valid) begin
            if (imem_rsp_valid) begin
              state_q <= REQ;
              kill_q  <= 1'b0;
            end else begin
              kill_q <= 1'b1;
            end
          end else if (imem_rsp_valid) begin
            if (kill_q) begin
              kill_q  <= 1'b0;
              state_q <= REQ;
            end else begin
              inst_buf_q <= imem_rsp_data;
              state_q    <= HOLD;
            end
          end
        end

        HOLD: begin
          if (redirect_valid || out_ready) begin
            state_q <= REQ;
            fault_q <= 1'b0;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/ysyx_23060042_ifu.md
# ysyx_23060042_ifu

Instruction fetch unit of the ysyx_23060042 core. It owns the program counter, issues fetch requests to instruction memory over a valid/ready request and valid-only response channel, and buffers one fetched instruction. It presents that instruction with its PC to the decode stage through a valid/ready handshake, and accepts PC redirects from the execute stage.

## Interface
- RESET_PC, 32'h8000_0000, PC loaded on reset
- clk  in  1  core clock, all state on posedge
- rst_n  in  1  asynchronous active-low reset
- redirect_valid  in  1  execute stage requests a PC change this cycle
- redirect_pc  in  32  target PC for the redirect
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts the request
- imem_req_addr  out  32  fetch address, always equal to the current PC
- imem_rsp_valid  in  1  memory returns data; at most one per accepted request, at least one cycle after acceptance
- imem_rsp_data  in  32  returned instruction word
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode consumes the instruction
- out_inst  out  32  instruction word to decode
- out_pc  out  32  PC of out_inst
- out_fault  out  1  instruction-address-misaligned flag; tied 0 without the macro

## Operation
- Registers: state, pc, inst_buf, kill.
- States: IDLE, REQ, WAIT, HOLD.
- IDLE: entered only on reset. All valids are 0. Moves to REQ on the first clock after rst_n deasserts.
- REQ: imem_req_valid=1.
  - On imem_req_ready, go to WAIT.
  - If redirect_valid is also high in the handshake cycle, the handshake still completes with the old pc. Set kill<=1 and pc<=redirect_pc.
  - If redirect_valid is high without a handshake, set pc<=redirect_pc and stay in REQ.
- WAIT: no request is issued.
  - On imem_rsp_valid with kill=0: inst_buf<=imem_rsp_data, go to HOLD.
  - On imem_rsp_valid with kill=1: drop the data, kill<=0, go to REQ.
  - On redirect_valid: pc<=redirect_pc. If imem_rsp_valid is high in the same cycle, drop the response and go to REQ. Otherwise set kill<=1 and stay in WAIT.
- HOLD: out_valid = !redirect_valid, out_inst=inst_buf, out_pc=pc.
  - On out_valid && out_ready: pc<=pc+4, go to REQ.
  - On redirect_valid: pc<=redirect_pc, go to REQ. No decode handshake occurs that cycle.
- PC arithmetic: 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Redirect always takes priority over sequential advance.

## Timing
- Reset values: state=IDLE, pc=RESET_PC, inst_buf=0, kill=0.
- Output values during and directly after reset: imem_req_valid=0, out_valid=0, imem_req_addr=RESET_PC, out_inst=0, out_pc=RESET_PC, out_fault=0.
- Best-case sequence with memory ready=1 and a 1-cycle response:
  - REQ at cycle 0.
  - Response in cycle 1.
  - out_valid in cycle 2.
  - Next REQ in cycle 3.
  - Throughput is one instruction per 3 cycles.
- Outputs to decode are registered, except that out_valid is gated combinationally by redirect_valid.
- Reset asserted mid-operation aborts any outstanding request. Memory is required to drop its in-flight response on reset; the IFU does not track it.
- out_inst/out_pc hold stable while out_valid=1 and out_ready=0.

## Configuration
- Macro: IFU_MISALIGN_CHK_EN.
- With the macro defined:
  - In REQ with pc[1:0]!=0, no request is issued (imem_req_valid=0).
  - Next cycle the state is HOLD with out_fault=1 and out_inst=32'h0000_0013 (NOP).
  - Fault consume or redirect leaves HOLD as normal, and out_fault returns to 0.
- Without the macro: pc[1:0] is ignored, the request is issued as is, and out_fault is constant 0.

## Structure
- Package ysyx_23060042_pkg holds:
  - the ifu_state_e enum {IDLE, REQ, WAIT, HOLD}
  - the RESET_PC_DEFAULT constant 32'h8000_0000
  - the INST_NOP constant 32'h0000_0013
- One sub-module, ysyx_23060042_ifu_pc: the PC register with redirect/advance mux. Inputs are redirect, advance, redirect_pc; output is pc.
- The FSM, kill flag and inst_buf live in the top module.

## Test plan
- Reset release, memory ready=1, 1-cycle response 32'h00000297, out_ready=1:
  - imem_req_addr = 32'h8000_0000 on the first request.
  - out_inst = 32'h00000297 with out_pc = 32'h8000_0000.
  - Next request address = 32'h8000_0004.
- Backpressure: out_ready=0 for 5 cycles in HOLD → out_valid stays 1, out_inst/out_pc stable, no new imem request; out_ready=1 → PC advances by 4.
- Redirect in WAIT to 32'h8000_0100 (no response that cycle) → the next response is dropped (no out_valid), then a request is issued with addr 32'h8000_0100.
- Redirect in HOLD to 32'h8000_0040 with out_ready=1 in the same cycle → out_valid=0 that cycle, next request addr = 32'h8000_0040.
- PC wrap: redirect to 32'hFFFF_FFFC, consume → next request addr = 32'h0000_0000.
- IFU_MISALIGN_CHK_EN defined: redirect to 32'h8000_0002 → no imem request; out_valid=1, out_fault=1, out_inst=32'h0000_0013, out_pc=32'h8000_0002.
